// File: rtl/dcache_sched_pkg.sv
// Shared types for the data-cache port scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dcache_sched_pkg;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_SB   = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCK_PIPE = 2'd1,
        ST_LOCK_SB   = 2'd2
    } state_e;

    // One outstanding cache request: who owns its data_ok and whether it is dropped.
    typedef struct packed {
        owner_e owner;
        logic   discard;
    } outst_ent_t;

endpackage

// File: rtl/outst_fifo.sv
// In-order outstanding-request FIFO with a broadcast "discard all pipeline entries" port.
// Latency: push visible at head next cycle; head is read combinationally.
// Backpressure: none internally; the caller must not push when full without popping.
// Ports: push/push_ent write, pop advances head, flush_pipe marks stored pipeline entries
//        discarded, head_ent/empty/full/count report state.
module outst_fifo
    import dcache_sched_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  outst_ent_t push_ent,
    input  logic       pop,
    input  logic       flush_pipe,
    output outst_ent_t head_ent,
    output logic       empty,
    output logic       full,
    output logic [AW:0] count
);

    outst_ent_t  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    // Pointers carry one extra wrap bit: full when only the MSB differs.
    assign count    = wptr - rptr;
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head_ent = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (flush_pipe) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].owner == OWN_PIPE) begin
                        mem[i].discard <= 1'b1;
                    end
                end
            end
            // Written after the broadcast so a same-cycle push keeps its own discard bit.
            if (push) begin
                mem[wptr[AW-1:0]] <= push_ent;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dcache_port_sched.sv
// Shares the single D-cache request port between the memory stage and the store-buffer drain.
// Latency: grant to cache_req_o 1 cycle (registered); data_ok to pipe/sb completion 0 cycles.
// Backpressure: request held stable until cache_addr_ok_i; no grant while the queue would be full.
// Ports: pipe_req_* / sb_req_* requesters, cache_* cache port, pipe_rdata_* / sb_done_o completions,
//        outst_num_o queue occupancy, error_o sticky protocol error.
module dcache_port_sched
    import dcache_sched_pkg::*;
#(
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 32,
    parameter  int OUTST_DEPTH = 4,
    parameter  int STARVE_MAX  = 8,
    localparam int CNT_W       = $clog2(OUTST_DEPTH) + 1,
    localparam int STRB_W      = DATA_W / 8,
    localparam int SC_W        = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_req_valid_i,
    input  logic              pipe_req_we_i,
    input  logic [ADDR_W-1:0] pipe_req_addr_i,
    input  logic [DATA_W-1:0] pipe_req_wdata_i,
    input  logic [STRB_W-1:0] pipe_req_wstrb_i,
    output logic              pipe_req_ready_o,
    input  logic              sb_req_valid_i,
    input  logic [ADDR_W-1:0] sb_req_addr_i,
    input  logic [DATA_W-1:0] sb_req_wdata_i,
    input  logic [STRB_W-1:0] sb_req_wstrb_i,
    output logic              sb_req_ready_o,
    input  logic              excep_flush_i,
    output logic              cache_req_o,
    output logic              cache_we_o,
    output logic [ADDR_W-1:0] cache_addr_o,
    output logic [DATA_W-1:0] cache_wdata_o,
    output logic [STRB_W-1:0] cache_wstrb_o,
    input  logic              cache_addr_ok_i,
    input  logic              cache_data_ok_i,
    input  logic [DATA_W-1:0] cache_rdata_i,
    output logic              pipe_rdata_ok_o,
    output logic [DATA_W-1:0] pipe_rdata_o,
    output logic              sb_done_o,
    output logic [CNT_W-1:0]  outst_num_o,
    output logic              error_o
);

    state_e          state;
    logic [SC_W-1:0] starve_cnt;
    logic            flush_pend;

    outst_ent_t      push_ent;
    outst_ent_t      head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            head_discard;

    logic            in_lock;
    logic            push;
    logic            pop;
    logic [CNT_W:0]  occ_next;
    logic            room;
    logic            pipe_cand;
    logic            sb_win;
    logic            pipe_win;
    logic            grant;

    assign in_lock  = (state != ST_IDLE);
    assign push     = in_lock && cache_addr_ok_i;
    assign pop      = cache_data_ok_i && !fifo_empty;

    // A new grant needs room after this cycle's push/pop, which allows back-to-back issue.
    assign occ_next = {1'b0, outst_num_o} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
    assign room     = (occ_next < (CNT_W+1)'(OUTST_DEPTH));

    // Flush kills the pipeline candidate; the store buffer wins when starved or uncontested.
    assign pipe_cand = pipe_req_valid_i && !excep_flush_i;
    assign sb_win    = sb_req_valid_i && ((starve_cnt == SC_W'(STARVE_MAX)) || !pipe_cand);
    assign pipe_win  = pipe_cand && !sb_win;
    assign grant     = (!in_lock || cache_addr_ok_i) && room && (sb_win || pipe_win);

    always_comb begin
        push_ent         = '0;
        push_ent.owner   = (state == ST_LOCK_SB) ? OWN_SB : OWN_PIPE;
        push_ent.discard = (state == ST_LOCK_PIPE) && (excep_flush_i || flush_pend);
    end

    // A flush in the pop cycle applies to the popped head as well.
    assign head_discard     = head.discard || (excep_flush_i && head.owner == OWN_PIPE);
    assign pipe_rdata_ok_o  = pop && (head.owner == OWN_PIPE) && !head_discard;
    assign sb_done_o        = pop && (head.owner == OWN_SB);
    assign pipe_rdata_o     = pipe_rdata_ok_o ? cache_rdata_i : '0;
    assign pipe_req_ready_o = (state == ST_LOCK_PIPE) && cache_addr_ok_i;
    assign sb_req_ready_o   = (state == ST_LOCK_SB) && cache_addr_ok_i;

    outst_fifo #(.DEPTH(OUTST_DEPTH)) u_outst_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_ent   (push_ent),
        .pop        (pop),
        .flush_pipe (excep_flush_i),
        .head_ent   (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (outst_num_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cache_req_o   <= 1'b0;
            cache_we_o    <= 1'b0;
            cache_addr_o  <= '0;
            cache_wdata_o <= '0;
            cache_wstrb_o <= '0;
            starve_cnt    <= '0;
            flush_pend    <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            if (grant) begin
                cache_req_o <= 1'b1;
                if (sb_win) begin
                    state         <= ST_LOCK_SB;
                    cache_we_o    <= 1'b1;
                    cache_addr_o  <= sb_req_addr_i;
                    cache_wdata_o <= sb_req_wdata_i;
                    cache_wstrb_o <= sb_req_wstrb_i;
                    starve_cnt    <= '0;
                end else begin
                    state         <= ST_LOCK_PIPE;
                    cache_we_o    <= pipe_req_we_i;
                    cache_addr_o  <= pipe_req_addr_i;
                    cache_wdata_o <= pipe_req_wdata_i;
                    cache_wstrb_o <= pipe_req_wstrb_i;
                    if (sb_req_valid_i) begin
                        starve_cnt <= starve_cnt + SC_W'(1);
                    end
                end
            end else if (push) begin
                state       <= ST_IDLE;
                cache_req_o <= 1'b0;
            end

            // Remember a flush that hits a held pipeline request until the cache takes it.
            if (push) begin
                flush_pend <= 1'b0;
            end else if (state == ST_LOCK_PIPE && excep_flush_i) begin
                flush_pend <= 1'b1;
            end

            if ((cache_data_ok_i && fifo_empty) ||
                (cache_addr_ok_i && !in_lock) ||
                (push && fifo_full && !pop)) begin
                error_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_port_sched.sv
// Scoreboard bench for dcache_port_sched: stimulus pushes expected completions,
// a monitor pops and compares on every pipe_rdata_ok_o / sb_done_o.
module tb_dcache_port_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_req_valid_i = 1'b0;
    logic        pipe_req_we_i = 1'b0;
    logic [31:0] pipe_req_addr_i = '0;
    logic [31:0] pipe_req_wdata_i = '0;
    logic [3:0]  pipe_req_wstrb_i = '0;
    logic        pipe_req_ready_o;
    logic        sb_req_valid_i = 1'b0;
    logic [31:0] sb_req_addr_i = '0;
    logic [31:0] sb_req_wdata_i = '0;
    logic [3:0]  sb_req_wstrb_i = '0;
    logic        sb_req_ready_o;
    logic        excep_flush_i = 1'b0;
    logic        cache_req_o;
    logic        cache_we_o;
    logic [31:0] cache_addr_o;
    logic [31:0] cache_wdata_o;
    logic [3:0]  cache_wstrb_o;
    logic        cache_addr_ok_i = 1'b0;
    logic        cache_data_ok_i = 1'b0;
    logic [31:0] cache_rdata_i = '0;
    logic        pipe_rdata_ok_o;
    logic [31:0] pipe_rdata_o;
    logic        sb_done_o;
    logic [2:0]  outst_num_o;
    logic        error_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          sb;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    dcache_port_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pipe_req_valid_i (pipe_req_valid_i),
        .pipe_req_we_i    (pipe_req_we_i),
        .pipe_req_addr_i  (pipe_req_addr_i),
        .pipe_req_wdata_i (pipe_req_wdata_i),
        .pipe_req_wstrb_i (pipe_req_wstrb_i),
        .pipe_req_ready_o (pipe_req_ready_o),
        .sb_req_valid_i   (sb_req_valid_i),
        .sb_req_addr_i    (sb_req_addr_i),
        .sb_req_wdata_i   (sb_req_wdata_i),
        .sb_req_wstrb_i   (sb_req_wstrb_i),
        .sb_req_ready_o   (sb_req_ready_o),
        .excep_flush_i    (excep_flush_i),
        .cache_req_o      (cache_req_o),
        .cache_we_o       (cache_we_o),
        .cache_addr_o     (cache_addr_o),
        .cache_wdata_o    (cache_wdata_o),
        .cache_wstrb_o    (cache_wstrb_o),
        .cache_addr_ok_i  (cache_addr_ok_i),
        .cache_data_ok_i  (cache_data_ok_i),
        .cache_rdata_i    (cache_rdata_i),
        .pipe_rdata_ok_o  (pipe_rdata_ok_o),
        .pipe_rdata_o     (pipe_rdata_o),
        .sb_done_o        (sb_done_o),
        .outst_num_o      (outst_num_o),
        .error_o          (error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (pipe_rdata_ok_o || sb_done_o)) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", {pipe_rdata_ok_o, sb_done_o}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_kind", {pipe_rdata_ok_o, sb_done_o}, e.sb ? 64'd1 : 64'd2);
                    if (!e.sb) chk("resp_data", pipe_rdata_o, e.data);
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_pipe(input logic we, input logic [31:0] a, input logic [31:0] wd);
        pipe_req_valid_i = 1'b1;
        pipe_req_we_i    = we;
        pipe_req_addr_i  = a;
        pipe_req_wdata_i = wd;
        pipe_req_wstrb_i = 4'hf;
        cyc(1);
        chk("pipe_grant_req", cache_req_o, 1);
        chk("pipe_grant_addr", cache_addr_o, a);
        chk("pipe_grant_we", cache_we_o, we);
        pipe_req_valid_i = 1'b0;
    endtask

    task automatic issue_sb(input logic [31:0] a, input logic [31:0] wd);
        sb_req_valid_i = 1'b1;
        sb_req_addr_i  = a;
        sb_req_wdata_i = wd;
        sb_req_wstrb_i = 4'h3;
        cyc(1);
        chk("sb_grant_req", cache_req_o, 1);
        chk("sb_grant_addr", cache_addr_o, a);
        chk("sb_grant_wdata", cache_wdata_o, wd);
        chk("sb_grant_we", cache_we_o, 1);
        sb_req_valid_i = 1'b0;
    endtask

    task automatic do_addr_ok(input bit sb);
        cache_addr_ok_i = 1'b1;
        #1;
        chk("ready_pipe", pipe_req_ready_o, !sb);
        chk("ready_sb", sb_req_ready_o, sb);
        cyc(1);
        cache_addr_ok_i = 1'b0;
    endtask

    task automatic do_data_ok(input logic [31:0] d);
        cache_data_ok_i = 1'b1;
        cache_rdata_i   = d;
        cyc(1);
        cache_data_ok_i = 1'b0;
    endtask

    task automatic flush_pulse();
        excep_flush_i = 1'b1;
        cyc(1);
        excep_flush_i = 1'b0;
    endtask

    initial begin
        int g;
        fork
            monitor();
        join_none

        // Reset state
        cyc(2);
        chk("rst_cache_req", cache_req_o, 0);
        chk("rst_outst", outst_num_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_pipe_ok", pipe_rdata_ok_o, 0);
        chk("rst_sb_done", sb_done_o, 0);
        chk("rst_cache_addr", cache_addr_o, 0);
        rst_n = 1'b1;
        cyc(1);

        // Single pipeline read
        exp_q.push_back('{sb: 1'b0, data: 32'hDEADBEEF});
        issue_pipe(1'b0, 32'h1000, 32'h0);
        chk("t1_outst_lock", outst_num_o, 0);
        cyc(1);
        chk("t1_addr_hold", cache_addr_o, 32'h1000);
        do_addr_ok(1'b0);
        chk("t1_outst_1", outst_num_o, 1);
        chk("t1_req_drop", cache_req_o, 0);
        cyc(2);
        do_data_ok(32'hDEADBEEF);
        chk("t1_outst_0", outst_num_o, 0);

        // Starvation: both valid, addr_ok every cycle
        pipe_req_valid_i = 1'b1; pipe_req_we_i = 1'b1; pipe_req_addr_i = 32'h2000;
        pipe_req_wdata_i = 32'h11; pipe_req_wstrb_i = 4'hf;
        sb_req_valid_i = 1'b1; sb_req_addr_i = 32'h3000; sb_req_wdata_i = 32'h55; sb_req_wstrb_i = 4'hf;
        g = 0;
        cyc(1);
        for (int c = 0; c < 30 && g < 9; c++) begin
            if (cache_req_o) begin
                g++;
                chk("starve_grant_addr", cache_addr_o, (g == 9) ? 32'h3000 : 32'h2000);
                exp_q.push_back('{sb: (g == 9), data: 32'h12345678});
                cache_addr_ok_i = 1'b1;
            end else begin
                cache_addr_ok_i = 1'b0;
            end
            cache_data_ok_i = (outst_num_o != 0);
            cache_rdata_i   = 32'h12345678;
            if (g == 9) begin
                pipe_req_valid_i = 1'b0;
                sb_req_valid_i   = 1'b0;
            end
            cyc(1);
        end
        cache_addr_ok_i = 1'b0;
        cache_data_ok_i = 1'b0;
        chk("starve_grant_count", g, 9);
        for (int k = 0; k < 10 && outst_num_o != 0; k++) do_data_ok(32'h12345678);
        chk("starve_drained", outst_num_o, 0);

        // After the SB grant the counter is clear: pipeline wins again
        pipe_req_valid_i = 1'b1;
        sb_req_valid_i   = 1'b1;
        cyc(1);
        chk("starve_reset_pipe_wins", cache_addr_o, 32'h2000);
        exp_q.push_back('{sb: 1'b0, data: 32'h12345678});
        pipe_req_valid_i = 1'b0;
        do_addr_ok(1'b0);
        chk("b2b_sb_req", cache_req_o, 1);
        chk("b2b_sb_addr", cache_addr_o, 32'h3000);
        exp_q.push_back('{sb: 1'b1, data: 32'h0});
        sb_req_valid_i = 1'b0;
        do_addr_ok(1'b1);
        chk("b2b_outst", outst_num_o, 2);
        do_data_ok(32'h12345678);
        do_data_ok(32'h0);

        // Two pipeline reads outstanding, then flush: both dropped
        issue_pipe(1'b0, 32'h4000, 32'h0);
        do_addr_ok(1'b0);
        issue_pipe(1'b0, 32'h4004, 32'h0);
        do_addr_ok(1'b0);
        chk("t3_outst_2", outst_num_o, 2);
        flush_pulse();
        do_data_ok(32'h1111);
        do_data_ok(32'h2222);
        chk("t3_outst_0", outst_num_o, 0);
        exp_q.push_back('{sb: 1'b0, data: 32'hCAFEF00D});
        issue_pipe(1'b0, 32'h4008, 32'h0);
        do_addr_ok(1'b0);
        do_data_ok(32'hCAFEF00D);

        // Flush while the pipeline request is held
        issue_pipe(1'b0, 32'h5000, 32'h0);
        flush_pulse();
        chk("t4_req_held", cache_req_o, 1);
        chk("t4_addr_held", cache_addr_o, 32'h5000);
        cyc(1);
        chk("t4_addr_held2", cache_addr_o, 32'h5000);
        do_addr_ok(1'b0);
        chk("t4_outst_1", outst_num_o, 1);
        do_data_ok(32'h0BAD0BAD);
        chk("t4_outst_0", outst_num_o, 0);

        // Store-buffer write survives a flush
        exp_q.push_back('{sb: 1'b1, data: 32'h0});
        issue_sb(32'h6000, 32'hA5A5A5A5);
        do_addr_ok(1'b1);
        flush_pulse();
        do_data_ok(32'h0);

        // Full queue blocks new grants until a pop
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{sb: 1'b0, data: 32'h100 + i});
            issue_pipe(1'b0, 32'h7000 + 4 * i, 32'h0);
            do_addr_ok(1'b0);
        end
        chk("t6_outst_4", outst_num_o, 4);
        exp_q.push_back('{sb: 1'b0, data: 32'h104});
        pipe_req_valid_i = 1'b1; pipe_req_we_i = 1'b0; pipe_req_addr_i = 32'h7100;
        cyc(1);
        chk("t6_blocked_1", cache_req_o, 0);
        cyc(2);
        chk("t6_blocked_3", cache_req_o, 0);
        cache_data_ok_i = 1'b1;
        cache_rdata_i   = 32'h100;
        cyc(1);
        cache_data_ok_i  = 1'b0;
        pipe_req_valid_i = 1'b0;
        chk("t6_grant_after_pop", cache_req_o, 1);
        chk("t6_grant_addr", cache_addr_o, 32'h7100);
        chk("t6_outst_3", outst_num_o, 3);
        do_addr_ok(1'b0);
        chk("t6_outst_4b", outst_num_o, 4);
        for (int i = 1; i <= 4; i++) do_data_ok(32'h100 + i);
        chk("t6_outst_0", outst_num_o, 0);

        // data_ok with nothing outstanding
        chk("err_before", error_o, 0);
        cache_data_ok_i = 1'b1;
        cyc(1);
        cache_data_ok_i = 1'b0;
        chk("err_set", error_o, 1);
        cyc(3);
        chk("err_sticky", error_o, 1);

        chk("scoreboard_empty", exp_q.size(), 0);

        // Reset in the middle of a held request aborts it
        issue_pipe(1'b0, 32'h8000, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", cache_req_o, 0);
        chk("rst_mid_error", error_o, 0);
        chk("rst_mid_outst", outst_num_o, 0);
        cyc(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_port_sched.md
# dcache_port_sched

Data-cache port scheduler between the memory stage and the data cache. It shares the single cache request port between the line1 memory-stage access (load/store/cacop) and the store-buffer drain. It holds each granted request stable until the cache accepts it, and tracks every accepted request in an in-order outstanding queue. Each returning `data_ok` is routed to its owner; responses belonging to flushed pipeline requests are silently discarded.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `OUTST_DEPTH`, 4: outstanding-queue entries (power of two, ≥2).
- `STARVE_MAX`, 8: consecutive pipeline grants tolerated while the store buffer waits.

- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pipe_req_valid_i` in 1: memory-stage request pending.
- `pipe_req_we_i` in 1: write (1) or read (0).
- `pipe_req_addr_i` in ADDR_W: address.
- `pipe_req_wdata_i` in DATA_W: write data.
- `pipe_req_wstrb_i` in DATA_W/8: byte strobes.
- `pipe_req_ready_o` out 1: pipeline request accepted by the cache this cycle.
- `sb_req_valid_i`, `sb_req_addr_i`, `sb_req_wdata_i`, `sb_req_wstrb_i`: store-buffer drain request; always a write; same widths as above.
- `sb_req_ready_o` out 1: store-buffer request accepted this cycle.
- `excep_flush_i` in 1: exception flush of the pipeline.
- `cache_req_o`, `cache_we_o`, `cache_addr_o`, `cache_wdata_o`, `cache_wstrb_o`: out; cache request.
- `cache_addr_ok_i` in 1: cache accepted the request.
- `cache_data_ok_i` in 1: in-order completion.
- `cache_rdata_i` in DATA_W: read data.
- `pipe_rdata_ok_o` out 1: completion for a live pipeline request.
- `pipe_rdata_o` out DATA_W: the completion's data.
- `sb_done_o` out 1: completion for a store-buffer write.
- `outst_num_o` out clog2(OUTST_DEPTH)+1: queue occupancy.
- `error_o` out 1: sticky protocol error.

## Operation
- FSM states:
  - IDLE → LOCK_PIPE or LOCK_SB when the arbiter grants and the queue is not full.
  - LOCK_x → IDLE on `cache_addr_ok_i`.
- Back-to-back grants: LOCK_x may go directly to the next LOCK on the same cycle as `addr_ok` if a request is pending and the queue will not be full.
- Arbitration: the pipeline wins by default. `starve_cnt` increments on every pipeline grant taken while `sb_req_valid_i`=1, and clears on any store-buffer grant. When `starve_cnt`==STARVE_MAX, the store buffer wins.
- In LOCK_x, `cache_*` outputs are driven from a registered copy of the winner's fields. They stay unchanged until `addr_ok`. The requester may deassert valid without effect.
- On `addr_ok`, the scheduler enqueues {owner, discard}:
  - discard = 1 if owner is the pipeline and either `excep_flush_i` is high this cycle or a flush arrived while in LOCK_PIPE (latched `flush_pend`).
  - discard = 0 otherwise.
- A flush in IDLE with `pipe_req_valid_i`=1 suppresses that pipeline grant this cycle.
- On flush, every queued pipeline entry gets discard set. Store-buffer entries are never discarded.
- On `data_ok`, the scheduler pops the head:
  - live pipeline entry: `pipe_rdata_ok_o`=1.
  - store-buffer entry: `sb_done_o`=1.
  - discarded entry: no output.
- Errors (sticky until reset):
  - `data_ok` with an empty queue.
  - `addr_ok` outside a LOCK state.
  - Push when full: impossible by design, but asserted.

## Timing
- Reset values: every output 0; FSM IDLE; queue empty; `starve_cnt`, `flush_pend`, `error_o` all 0. Reset mid-LOCK aborts the request; outstanding responses are lost.
- Grant to `cache_req_o`: 1 cycle (registered).
- `*_ready_o` is combinational, equal to `addr_ok` in the matching LOCK state.
- `pipe_rdata_ok_o`, `sb_done_o` and `pipe_rdata_o` are combinational from `data_ok` (0 extra cycles).
- Simultaneous push and pop on a full queue is allowed; occupancy is unchanged.
- Same-cycle flush and pop: the popped entry uses its discard bit after the flush update. A flush applies to the head it pops.
- Pointer wrap: modulo OUTST_DEPTH with an extra wrap bit; full when the pointers differ only in the MSB.

## Structure
- Shared package `dcache_sched_pkg`: owner encoding (`OWN_PIPE`=0, `OWN_SB`=1), FSM state enum, queue-entry struct.
- Sub-module `outst_fifo`: a parameterized FIFO with a broadcast "set discard where owner==PIPE" port.

## Test plan
- Pipeline read to 0x1000. `addr_ok` 2 cycles after `cache_req_o`, `data_ok` 3 cycles later with 0xDEADBEEF → `pipe_rdata_ok_o`=1 with 0xDEADBEEF; `outst_num_o` goes 0→1→0.
- Pipeline and store buffer valid continuously, `addr_ok` every cycle → store buffer granted on the 9th grant; `starve_cnt` resets.
- Two pipeline reads outstanding, flush, then 2 × `data_ok` → no `pipe_rdata_ok_o`; a fresh read issued after the flush returns normally.
- Flush while in LOCK_PIPE, `addr_ok` 2 cycles later → request held stable, entry discarded, its `data_ok` suppressed.
- Store-buffer write outstanding plus flush → `sb_done_o`=1 on its `data_ok`.
- `data_ok` with an empty queue → `error_o`=1 the next cycle and stays 1. With 4 outstanding, `cache_req_o` stays 0 until a pop.
